// File: rtl/spram_arb2.sv
// Two-requester round-robin arbiter that drives a single-port synchronous RAM
// and steers the 1-cycle read data back to its owner. Optional lock feature: SPRAM_ARB_LOCK_EN.
module spram_arb2 #(
    parameter int WD       = 8,
    parameter int AD       = 4,
    parameter int LOCK_MAX = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AD-1:0] addr0,
    input  logic [AD-1:0] addr1,
    input  logic [WD-1:0] wdata0,
    input  logic [WD-1:0] wdata1,
`ifdef SPRAM_ARB_LOCK_EN
    input  logic          lock0,
    input  logic          lock1,
`endif
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [WD-1:0] rdata0,
    output logic [WD-1:0] rdata1,
    output logic          ram_cs_n,
    output logic          ram_w_r_n,
    output logic [AD-1:0] ram_addr,
    output logic [WD-1:0] ram_din,
    input  logic [WD-1:0] ram_dout
);

    logic last_gnt_q, last_gnt_d;
    logic ownr_valid_q, ownr_valid_d;
    logic ownr_id_q, ownr_id_d;
    logic any_gnt;

`ifdef SPRAM_ARB_LOCK_EN
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       hold_owner;
    logic       owner_locked;
    logic       sel_lock;

    // The previous owner keeps the bus while it asserts lock, up to LOCK_MAX grants.
    assign owner_locked = last_gnt_q ? (req1 & lock1) : (req0 & lock0);
    assign hold_owner   = owner_locked && (lock_cnt_q < 8'(LOCK_MAX));
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
`ifdef SPRAM_ARB_LOCK_EN
        if (hold_owner) begin
            gnt0 = ~last_gnt_q;
            gnt1 = last_gnt_q;
        end else
`endif
        if (req0 && req1) begin
            gnt0 = last_gnt_q;
            gnt1 = ~last_gnt_q;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    assign any_gnt = gnt0 | gnt1;

    always_comb begin
        ram_cs_n  = 1'b1;
        ram_w_r_n = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        if (gnt0) begin
            ram_cs_n  = 1'b0;
            ram_w_r_n = we0;
            ram_addr  = addr0;
            ram_din   = wdata0;
        end else if (gnt1) begin
            ram_cs_n  = 1'b0;
            ram_w_r_n = we1;
            ram_addr  = addr1;
            ram_din   = wdata1;
        end
    end

    // An accepted read marks its owner so the RAM's registered dout is routed back next cycle.
    always_comb begin
        last_gnt_d   = any_gnt ? gnt1 : last_gnt_q;
        ownr_valid_d = any_gnt && !ram_w_r_n;
        ownr_id_d    = any_gnt ? gnt1 : ownr_id_q;
    end

`ifdef SPRAM_ARB_LOCK_EN
    assign sel_lock = (gnt0 & lock0) | (gnt1 & lock1);

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (any_gnt) begin
            if (!sel_lock) begin
                lock_cnt_d = 8'd0;
            end else if (gnt1 != last_gnt_q) begin
                lock_cnt_d = 8'd1;
            end else if (lock_cnt_q != 8'hFF) begin
                lock_cnt_d = lock_cnt_q + 8'd1;
            end
        end else if (!(last_gnt_q ? lock1 : lock0)) begin
            lock_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= 8'd0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt_q   <= 1'b1;
            ownr_valid_q <= 1'b0;
            ownr_id_q    <= 1'b0;
        end else begin
            last_gnt_q   <= last_gnt_d;
            ownr_valid_q <= ownr_valid_d;
            ownr_id_q    <= ownr_id_d;
        end
    end

    assign rvalid0 = ownr_valid_q & ~ownr_id_q;
    assign rvalid1 = ownr_valid_q & ownr_id_q;
    assign rdata0  = rvalid0 ? ram_dout : '0;
    assign rdata1  = rvalid1 ? ram_dout : '0;

endmodule

// File: tb/tb_spram_arb2.sv
// Self-checking bench for spram_arb2: a behavioural RAM plus a reference model
// tracking last grant, shadow memory contents and the pending read.
module tb_spram_arb2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1, we0, we1;
    logic [3:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       ram_cs_n, ram_w_r_n;
    logic [3:0] ram_addr;
    logic [7:0] ram_din, ram_dout;
`ifdef SPRAM_ARB_LOCK_EN
    logic       lock0 = 1'b0;
    logic       lock1 = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] refMem [16];
    int         expLast;
    logic       pendV;
    int         pendId;
    logic [7:0] pendData;

    // Expectations for the current cycle
    int         expG;
    logic       expG0, expG1, expCs, expWr, expRv0, expRv1;
    logic [3:0] expAddr;
    logic [7:0] expDin, expRd0, expRd1;

    logic [7:0] ramMem [16];

    spram_arb2 #(.WD(8), .AD(4), .LOCK_MAX(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef SPRAM_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .ram_cs_n(ram_cs_n), .ram_w_r_n(ram_w_r_n), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with a registered read port
    always @(posedge clk) begin
        if (!ram_cs_n) begin
            if (ram_w_r_n) ramMem[ram_addr] <= ram_din;
            else           ram_dout <= ramMem[ram_addr];
        end
    end

    task automatic modelReset();
        expLast = 1;
        pendV   = 1'b0;
        pendId  = 0;
        pendData = 8'h00;
    endtask

    // Drive one cycle's inputs at the falling edge and predict every output
    task automatic applyStimulus(input logic r0, input logic w0, input logic [3:0] a0, input logic [7:0] d0,
                                 input logic r1, input logic w1, input logic [3:0] a1, input logic [7:0] d1);
        @(negedge clk);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        expRv0 = pendV && (pendId == 0);
        expRv1 = pendV && (pendId == 1);
        expRd0 = expRv0 ? pendData : 8'h00;
        expRd1 = expRv1 ? pendData : 8'h00;
        if (r0 && r1)  expG = (expLast == 1) ? 0 : 1;
        else if (r0)   expG = 0;
        else if (r1)   expG = 1;
        else           expG = 2;
        expG0   = (expG == 0);
        expG1   = (expG == 1);
        expCs   = (expG == 2);
        expWr   = expG0 ? w0 : (expG1 ? w1 : 1'b0);
        expAddr = expG0 ? a0 : (expG1 ? a1 : 4'h0);
        expDin  = expG0 ? d0 : (expG1 ? d1 : 8'h00);
        #1;
    endtask

    // Advance the model as the next rising edge will
    task automatic commit();
        if (expG != 2) begin
            expLast = expG;
            if (expWr) begin
                refMem[expAddr] = expDin;
                pendV = 1'b0;
            end else begin
                pendV    = 1'b1;
                pendId   = expG;
                pendData = refMem[expAddr];
            end
        end else begin
            pendV = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        modelReset();
        repeat (2) @(negedge clk);
        total++;
        if ({gnt0, gnt1, ram_cs_n} !== 3'b001) begin
            bad++; $display("[TB] FAIL reset_gnt_cs got=%b want=001", {gnt0, gnt1, ram_cs_n});
        end
        total++;
        if ({rvalid0, rvalid1, rdata0, rdata1} !== 18'h0) begin
            bad++; $display("[TB] FAIL reset_rvalid got=%b%b %h %h want=00 00 00", rvalid0, rvalid1, rdata0, rdata1);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write_read();
        applyStimulus(1, 1, 4'd3, 8'hA5, 0, 0, 4'd0, 8'h00);
        total++;
        if ({gnt0, gnt1, ram_cs_n, ram_w_r_n, ram_addr, ram_din} !== {4'b1001, 4'd3, 8'hA5}) begin
            bad++; $display("[TB] FAIL wr_pins got=%b%b%b%b %h %h want=1001 3 a5", gnt0, gnt1, ram_cs_n, ram_w_r_n, ram_addr, ram_din);
        end
        commit();
        applyStimulus(0, 0, 4'd0, 8'h00, 1, 0, 4'd3, 8'h00);
        total++;
        if ({gnt1, ram_cs_n, ram_w_r_n, ram_addr} !== {3'b100, 4'd3}) begin
            bad++; $display("[TB] FAIL rd_pins got=%b%b%b %h want=100 3", gnt1, ram_cs_n, ram_w_r_n, ram_addr);
        end
        commit();
        applyStimulus(1, 1, 4'd1, 8'($urandom), 0, 0, 4'd0, 8'h00);
        total++;
        if ({rvalid0, rvalid1, rdata1} !== {2'b01, 8'hA5} || rdata0 !== 8'h00) begin
            bad++; $display("[TB] FAIL rd_data got=%b%b %h %h want=01 a5 00", rvalid0, rvalid1, rdata1, rdata0);
        end
        commit();
        applyStimulus(0, 0, 4'd0, 8'h00, 1, 1, 4'd2, 8'($urandom));
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== {expG0, expG1, expRv0, expRv1}) begin
            bad++; $display("[TB] FAIL wr2_gnt got=%b%b%b%b want=%b%b%b%b", gnt0, gnt1, rvalid0, rvalid1, expG0, expG1, expRv0, expRv1);
        end
        commit();
    endtask

    task automatic test_contention();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) applyStimulus(1, 0, 4'd1, 8'h00, 1, 0, 4'd2, 8'h00);
            else       applyStimulus(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
            total++;
            if (i < 4 && {gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                bad++; $display("[TB] FAIL alt_gnt cyc=%0d got=%b%b want=%s", i, gnt0, gnt1, (i % 2 == 0) ? "10" : "01");
            end else if ({rvalid0, rvalid1, rdata0, rdata1} !== {expRv0, expRv1, expRd0, expRd1}) begin
                bad++; $display("[TB] FAIL alt_rdata cyc=%0d got=%b%b %h %h want=%b%b %h %h", i, rvalid0, rvalid1, rdata0, rdata1, expRv0, expRv1, expRd0, expRd1);
            end
            commit();
        end
    endtask

    task automatic test_fill();
        for (int a = 0; a < 16; a++) begin
            applyStimulus(1, 1, 4'(a), 8'($urandom), 0, 0, 4'd0, 8'h00);
            total++;
            if ({gnt0, ram_cs_n, ram_w_r_n, ram_addr, ram_din} !== {3'b101, expAddr, expDin}) begin
                bad++; $display("[TB] FAIL fill a=%0d got=%b%b%b %h %h want=101 %h %h", a, gnt0, ram_cs_n, ram_w_r_n, ram_addr, ram_din, expAddr, expDin);
            end
            commit();
        end
    endtask

    task automatic test_single_req1();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) applyStimulus(0, 0, 4'd0, 8'h00, 1, 0, 4'(i + 8), 8'h00);
            else       applyStimulus(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
            total++;
            if ({gnt0, gnt1} !== {1'b0, i < 3} || {rvalid0, rvalid1} !== {1'b0, i > 0} || rdata1 !== expRd1) begin
                bad++; $display("[TB] FAIL single1 cyc=%0d got=%b%b %b%b %h want=0%b 0%b %h", i, gnt0, gnt1, rvalid0, rvalid1, rdata1, i < 3, i > 0, expRd1);
            end
            commit();
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
            total++;
            if ({ram_cs_n, ram_w_r_n, ram_addr, ram_din, rdata0, rdata1} !== {2'b10, 4'h0, 24'h0} || (i > 0 && (rvalid0 | rvalid1))) begin
                bad++; $display("[TB] FAIL idle cyc=%0d got=%b%b %h %h %h %h", i, ram_cs_n, ram_w_r_n, ram_addr, ram_din, rdata0, rdata1);
            end
            commit();
        end
        applyStimulus(1, 0, 4'd4, 8'h00, 1, 0, 4'd5, 8'h00);
        total++;
        if ({gnt0, gnt1} !== {expG0, expG1}) begin
            bad++; $display("[TB] FAIL idle_last got=%b%b want=%b%b", gnt0, gnt1, expG0, expG1);
        end
        commit();
    endtask

    task automatic test_reset_mid_read();
        applyStimulus(1, 0, 4'd5, 8'h00, 0, 0, 4'd0, 8'h00);
        commit();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req0 = 0; req1 = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++;
            if ({rvalid0, rvalid1, ram_cs_n} !== 3'b001) begin
                bad++; $display("[TB] FAIL rst_mid cyc=%0d got=%b%b%b want=001", i, rvalid0, rvalid1, ram_cs_n);
            end
        end
        rst_n = 1'b1;
        modelReset();
        applyStimulus(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
        total++;
        if ({rvalid0, rvalid1} !== 2'b00) begin
            bad++; $display("[TB] FAIL rst_release_rvalid got=%b%b want=00", rvalid0, rvalid1);
        end
        commit();
        applyStimulus(1, 0, 4'd6, 8'h00, 1, 0, 4'd7, 8'h00);
        total++;
        if ({gnt0, gnt1} !== 2'b10) begin
            bad++; $display("[TB] FAIL rst_first_gnt got=%b%b want=10", gnt0, gnt1);
        end
        commit();
        applyStimulus(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
        total++;
        if ({rvalid0, rvalid1, rdata0} !== {2'b10, refMem[6]}) begin
            bad++; $display("[TB] FAIL rst_first_rd got=%b%b %h want=10 %h", rvalid0, rvalid1, rdata0, refMem[6]);
        end
        commit();
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 2) != 0, 1'($urandom), 4'($urandom), 8'($urandom),
                          $urandom_range(0, 2) != 0, 1'($urandom), 4'($urandom), 8'($urandom));
            total++;
            if ({gnt0, gnt1, ram_cs_n, ram_w_r_n, ram_addr, ram_din} !== {expG0, expG1, expCs, expWr, expAddr, expDin}) begin
                bad++; $display("[TB] FAIL rnd_cmd cyc=%0d got=%b%b%b%b %h %h want=%b%b%b%b %h %h", i, gnt0, gnt1, ram_cs_n, ram_w_r_n, ram_addr, ram_din, expG0, expG1, expCs, expWr, expAddr, expDin);
            end
            total++;
            if ({rvalid0, rvalid1, rdata0, rdata1} !== {expRv0, expRv1, expRd0, expRd1}) begin
                bad++; $display("[TB] FAIL rnd_rd cyc=%0d got=%b%b %h %h want=%b%b %h %h", i, rvalid0, rvalid1, rdata0, rdata1, expRv0, expRv1, expRd0, expRd1);
            end
            commit();
        end
    endtask

`ifdef SPRAM_ARB_LOCK_EN
    task automatic test_lock();
        applyStimulus(0, 0, 4'd0, 8'h00, 0, 0, 4'd0, 8'h00);
        lock0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1, 0, 4'd1, 8'h00, 1, 0, 4'd2, 8'h00);
            total++;
            if ({gnt0, gnt1} !== ((i == 3) ? 2'b01 : 2'b10)) begin
                bad++; $display("[TB] FAIL lock cyc=%0d got=%b%b want=%s", i, gnt0, gnt1, (i == 3) ? "01" : "10");
            end
        end
        lock0 = 1'b0;
    endtask
`endif

    initial begin
        for (int a = 0; a < 16; a++) refMem[a] = 8'h00;
        test_reset();
        test_write_read();
        test_contention();
        test_fill();
        test_single_req1();
        test_idle();
        test_reset_mid_read();
        test_random();
`ifdef SPRAM_ARB_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spram_arb2.md
Name: spram_arb2

Overview:
- Two-requester round-robin arbiter and sequencer in front of the team's single-port synchronous RAM (cs_n / w_r_n / addr / din / dout, 1-cycle registered read).
- Each cycle, grants at most one requester, drives the RAM command pins directly and routes returned read data back to the owner with a valid strobe.
- Sits between two client engines (e.g. DMA and CPU-side port) and one RAM instance.

Parameters:
- WD, 8, data width; matches RAM WD.
- AD, 4, address width; matches RAM AD.
- LOCK_MAX, 8, max consecutive locked grants to one requester; used only with SPRAM_ARB_LOCK_EN, legal range 1..255.

Ports:
- clk  input  1  rising-edge clock shared with the RAM.
- rst_n  input  1  asynchronous, active-low reset.
- req0, req1  input  1 each  request from requester 0/1; held with its command fields stable until granted.
- we0, we1  input  1 each  1 = write, 0 = read.
- addr0, addr1  input  AD each  address.
- wdata0, wdata1  input  WD each  write data.
- gnt0, gnt1  output  1 each  combinational grant; command is accepted in a cycle where req and gnt are both 1.
- rvalid0, rvalid1  output  1 each  read data valid, registered.
- rdata0, rdata1  output  WD each  read data; 0 whenever the matching rvalid is 0.
- ram_cs_n  output  1  to RAM cs_n.
- ram_w_r_n  output  1  to RAM w_r_n; 1 = write.
- ram_addr  output  AD  to RAM addr.
- ram_din  output  WD  to RAM din.
- ram_dout  input  WD  from RAM dout.

Behaviour:
- Reset (rst_n low, async):
  - last_gnt = 1, so requester 0 wins the first contention.
  - rvalid0 = rvalid1 = 0; lock counter = 0.
  - Combinational outputs follow with all req low: gnt = 0, ram_cs_n = 1, rdata = 0.
- Arbitration is combinational from req0, req1 and the last_gnt register:
  - Only one requester active: that requester is granted.
  - Both active: the requester not equal to last_gnt is granted.
  - None active: no grant, ram_cs_n = 1, ram_w_r_n = 0, ram_addr = 0, ram_din = 0.
- On a grant, RAM pins are driven in the same cycle:
  - ram_cs_n = 0, ram_w_r_n = weX, ram_addr = addrX, ram_din = wdataX.
  - The RAM samples them on the next rising edge.
  - last_gnt updates to X on that edge.
- Read latency:
  - A read accepted in cycle N asserts rvalidX for exactly cycle N+1.
  - rdataX = ram_dout during that cycle.
  - Implemented via an owner register (ownr_valid, ownr_id) loaded on an accepted read.
- Writes produce no rvalid; write data is in RAM from edge N+1.
- Back-to-back: one accepted command per cycle sustained, so a read in N and a read in N+1 give rvalid in N+1 and N+2.
- Same-address write by one requester and read by the other in consecutive cycles: the read returns the new data, because the RAM is written on the earlier edge.
- Request withdrawn before grant is permitted; no state change.
- Reset mid-read: a pending rvalid is cancelled; no rvalid is emitted after reset release.
- Idle cycles do not move last_gnt.

Optional Feature:
- Macro: SPRAM_ARB_LOCK_EN.
- Defined:
  - Adds inputs lock0 and lock1 (1 bit each).
  - While the current owner holds reqX & lockX, it keeps the grant even if the other requester is active.
  - A 8-bit counter counts consecutive locked grants.
  - When the count reaches LOCK_MAX, the next cycle grants the other requester if it is requesting.
  - The counter clears on any owner change or when lockX drops.
- Undefined:
  - lock ports absent; pure round-robin as above.
  - No lock counter logic.

Test Plan:
- Reset, then req0=1 write addr=3 wdata=8'hA5 -> gnt0=1 same cycle, ram_cs_n=0, ram_w_r_n=1, ram_addr=3; next, req1 read addr=3 -> rvalid1=1 one cycle later with rdata1=8'hA5, rvalid0 stays 0.
- req0 and req1 both held for 4 cycles reading addr 1 and 2 -> grants alternate 0,1,0,1 starting with 0; rvalid pattern 0,1,0,1 shifted by one cycle with correct data.
- Only req1 for 3 consecutive cycles -> gnt1 every cycle, no bubbles, 3 consecutive rvalid1 pulses.
- Assert rst_n low in the cycle after a read is accepted -> rvalid0/1 stay 0; after release, the first contention is granted to requester 0.
- No requests for 5 cycles -> ram_cs_n=1 throughout, rdata0=rdata1=0, last_gnt unchanged.
- With SPRAM_ARB_LOCK_EN, LOCK_MAX=3, req0+lock0 and req1 held -> gnt0 for 3 cycles, then gnt1 for 1 cycle, then gnt0 again.
